// File: rtl/cell_mem_pkg.sv
`default_nettype none
// ============================================================================
// cell_mem_pkg : shared constants, FSM encoding and FIFO entry type for the
//                cell position memory read path.
// Revision     : 1.0
// ============================================================================
package cell_mem_pkg;

    localparam int DATA_WIDTH   = 96;
    localparam int ADDR_WIDTH   = 8;
    localparam int PARTICLE_NUM = 220;
    localparam int RD_LATENCY   = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int COUNT_LSB    = 0;
    localparam int OCC_WIDTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_FIN      = 3'd4
    } state_e;

    typedef struct packed {
        logic                  last;
        logic [ADDR_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0] data;
    } pos_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] clamp_count(
        input logic [ADDR_WIDTH-1:0] raw,
        input int                    max_count
    );
        if (int'(raw) > max_count) return ADDR_WIDTH'(max_count);
        return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_pos_skid_fifo.sv
`default_nettype none
// ============================================================================
// cell_pos_skid_fifo : read-latency tag pipeline feeding a first-word-fall-
//                      through FIFO of tagged particle words.
// Revision           : 1.0
// ============================================================================
module cell_pos_skid_fifo
    import cell_mem_pkg::*;
#(
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int LATENCY = RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_id,
    input  logic                  issue_last,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  pop,
    output logic                  head_valid,
    output pos_entry_t            head,
    output logic [OCC_WIDTH-1:0]  count,
    output logic [OCC_WIDTH-1:0]  inflight
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LATENCY-1:0]    tag_valid_q, tag_valid_d;
    logic [LATENCY-1:0]    tag_last_q, tag_last_d;
    logic [ADDR_WIDTH-1:0] tag_id_q [LATENCY];
    logic [ADDR_WIDTH-1:0] tag_id_d [LATENCY];
    pos_entry_t            slot_q [DEPTH];
    pos_entry_t            slot_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]  count_q, count_d;
    logic                  push, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Tag travels alongside the read so data lands exactly LATENCY cycles later
        tag_valid_d[0] = issue_valid;
        tag_last_d[0]  = issue_last;
        tag_id_d[0]    = issue_id;
        for (int i = 1; i < LATENCY; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_last_d[i]  = tag_last_q[i-1];
            tag_id_d[i]    = tag_id_q[i-1];
        end

        push     = tag_valid_q[LATENCY-1];
        pop_ok   = pop && (count_q != '0);
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            slot_d[wr_ptr_q].last = tag_last_q[LATENCY-1];
            slot_d[wr_ptr_q].id   = tag_id_q[LATENCY-1];
            slot_d[wr_ptr_q].data = rd_data;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + OCC_WIDTH'(push) - OCC_WIDTH'(pop_ok);

        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + OCC_WIDTH'(tag_valid_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) slot_q[j] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
            for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= tag_id_d[i];
            for (int j = 0; j < DEPTH; j++) slot_q[j] <= slot_d[j];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head       = slot_q[rd_ptr_q];
    assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/cell_pos_reader.sv
`default_nettype none
// ============================================================================
// cell_pos_reader : reads a cell's particle count from word 0, then streams
//                   words 1..count with credit-based backpressure.
// Revision        : 1.0
// ============================================================================
module cell_pos_reader
    import cell_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] pos_data,
    output logic [ADDR_WIDTH-1:0] pos_id,
    output logic                  pos_valid,
    output logic                  pos_last,
    input  logic                  pos_ready,
    output logic [ADDR_WIDTH-1:0] cell_count
);

    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] cell_count_q, cell_count_d;
    logic [ADDR_WIDTH:0]   next_addr_q, next_addr_d;
    logic                  mem_rden_q, mem_rden_d;
    logic                  issue_q, issue_d;
    logic                  issue_last_q, issue_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  head_valid;
    pos_entry_t            head;
    logic [OCC_WIDTH-1:0]  fill_count, inflight;
    logic [OCC_WIDTH-1:0]  credit_used;
    logic                  credit_ok;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] latched_count;

    assign pop           = head_valid && pos_ready;
    assign latched_count = clamp_count(mem_q[COUNT_LSB +: ADDR_WIDTH], PARTICLE_NUM - 1);

    // Every read in flight already owns a FIFO slot; a pop this cycle frees one
    assign credit_used = OCC_WIDTH'(issue_q) + inflight + fill_count - OCC_WIDTH'(pop);
    assign credit_ok   = credit_used < OCC_WIDTH'(FIFO_DEPTH);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        cell_count_d = cell_count_q;
        next_addr_d  = next_addr_q;
        busy_d       = busy_q;
        mem_rden_d   = 1'b0;
        issue_d      = 1'b0;
        issue_last_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RD_CNT;
                    busy_d     = 1'b1;
                    mem_rden_d = 1'b1;
                    mem_addr_d = '0;
                end
            end
            ST_RD_CNT: begin
                state_d    = ST_WAIT_CNT;
                wait_cnt_d = '0;
            end
            ST_WAIT_CNT: begin
                if (wait_cnt_q == WAIT_W'(RD_LATENCY - 1)) begin
                    cell_count_d = latched_count;
                    if (latched_count == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_STREAM;
                        mem_rden_d   = 1'b1;
                        issue_d      = 1'b1;
                        mem_addr_d   = ADDR_WIDTH'(1);
                        issue_last_d = (latched_count == ADDR_WIDTH'(1));
                        next_addr_d  = (ADDR_WIDTH + 1)'(2);
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if ((next_addr_q <= {1'b0, cell_count_q}) && credit_ok) begin
                    mem_rden_d   = 1'b1;
                    issue_d      = 1'b1;
                    mem_addr_d   = next_addr_q[ADDR_WIDTH-1:0];
                    issue_last_d = (next_addr_q == {1'b0, cell_count_q});
                    next_addr_d  = next_addr_q + 1'b1;
                end
                if (pop && head.last) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            mem_addr_q   <= '0;
            cell_count_q <= '0;
            next_addr_q  <= '0;
            mem_rden_q   <= 1'b0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_addr_q   <= mem_addr_d;
            cell_count_q <= cell_count_d;
            next_addr_q  <= next_addr_d;
            mem_rden_q   <= mem_rden_d;
            issue_q      <= issue_d;
            issue_last_q <= issue_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    cell_pos_skid_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LATENCY (RD_LATENCY)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_q),
        .issue_id    (mem_addr_q),
        .issue_last  (issue_last_q),
        .rd_data     (mem_q),
        .pop         (pop),
        .head_valid  (head_valid),
        .head        (head),
        .count       (fill_count),
        .inflight    (inflight)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rden   = mem_rden_q;
    assign mem_wren   = 1'b0;
    assign cell_count = cell_count_q;
    assign pos_valid  = head_valid;
    assign pos_data   = head.data;
    assign pos_id     = head.id;
    assign pos_last   = head.last;

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_reader.sv
`default_nettype none
// ============================================================================
// tb_cell_pos_reader : directed bench with a 2-cycle-latency cell RAM model
//                      and a handshake scoreboard.
// Revision           : 1.0
// ============================================================================
module tb_cell_pos_reader;
    import cell_mem_pkg::*;

    localparam int MAXC = PARTICLE_NUM - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic                  pos_ready = 1'b1;
    logic                  busy, done, mem_rden, mem_wren, pos_valid, pos_last;
    logic [ADDR_WIDTH-1:0] mem_addr, pos_id, cell_count;
    logic [DATA_WIDTH-1:0] mem_q, pos_data, rd_stage;
    logic [DATA_WIDTH-1:0] ram [256];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int exp_id, exp_cnt, cur_base, words, done_cnt, start_cyc;
    int first_valid, first_hs, last_hs, done_cyc, max_occ;
    bit mon_en = 1'b0;
    bit hold, prev_done, busy_at_done, busy_after_done, any_valid;
    logic [DATA_WIDTH-1:0] held_data;
    logic [ADDR_WIDTH-1:0] held_id;
    logic                  held_last;

    cell_pos_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q),
        .pos_data   (pos_data),
        .pos_id     (pos_id),
        .pos_valid  (pos_valid),
        .pos_last   (pos_last),
        .pos_ready  (pos_ready),
        .cell_count (cell_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_rden) rd_stage <= ram[mem_addr];
        mem_q <= rd_stage;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] word_of(input int base, input int id);
        return {32'(base * 1000 + id), 32'(id * 32'h0101_0101), 32'(base + id * 7)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (hold) begin
                check_eq("hold_valid", pos_valid, 1);
                check_eq("hold_data", pos_data, held_data);
                check_eq("hold_id", pos_id, held_id);
                check_eq("hold_last", pos_last, held_last);
            end
            if (pos_valid) begin
                any_valid = 1'b1;
                if (first_valid < 0) first_valid = cyc;
            end
            if (pos_valid && pos_ready) begin
                check_eq("id", pos_id, exp_id);
                check_eq("data", pos_data, word_of(cur_base, exp_id));
                check_eq("last", pos_last, exp_id == exp_cnt);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                exp_id++;
                words++;
            end
            hold      = pos_valid && !pos_ready;
            held_data = pos_data;
            held_id   = pos_id;
            held_last = pos_last;
            if (prev_done) busy_after_done = busy;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            prev_done = done;
            if (int'(dut.u_fifo.count_q) > max_occ) max_occ = int'(dut.u_fifo.count_q);
        end
    end

    task automatic arm(input int raw, input int base);
        ram[0] = {32'(32'hC0DE_0000 + base), 32'h1357_9BDF, 24'hA5A5A5, 8'(raw)};
        for (int i = 1; i < 256; i++) ram[i] = word_of(base, i);
        cur_base = base;
        exp_cnt = (raw > MAXC) ? MAXC : raw;
        exp_id = 1; words = 0; done_cnt = 0; max_occ = 0;
        first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
        hold = 1'b0; prev_done = 1'b0; any_valid = 1'b0;
        busy_at_done = 1'b0; busy_after_done = 1'b1;
        mon_en = 1'b1;
    endtask

    // restart_at: cycle after start at which start is pulsed again (-1 = never)
    task automatic run_cell(input int raw, input int base, input bit rnd, input int restart_at);
        int k, tail;
        arm(raw, base);
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        pos_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        k = 0; tail = 0;
        while (tail < 6 && k < 3000) begin
            @(posedge clk); #1;
            k++;
            start = (k == restart_at);
            pos_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cnt > 0 && k > restart_at) tail++;
        end
        start = 1'b0;
        pos_ready = 1'b1;
        check_eq("no_timeout", k < 3000, 1);
        check_eq("done_count", done_cnt, 1);
        check_eq("words", words, exp_cnt);
        check_eq("busy_end", busy, 0);
    endtask

    initial begin
        int k;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", pos_valid, 0);
        check_eq("rst_rden", mem_rden, 0);
        check_eq("rst_wren", mem_wren, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_count", cell_count, 0);
        check_eq("rst_data", pos_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // count=5 at full throughput
        run_cell(5, 100, 1'b0, -1);
        check_eq("t1_first_valid_lat", first_valid - start_cyc, 7);
        check_eq("t1_back_to_back", last_hs - first_hs, 4);
        check_eq("t1_done_after_last", done_cyc - last_hs, 1);
        check_eq("t1_cell_count", cell_count, 5);
        check_eq("t1_busy_at_done", busy_at_done, 1);

        // empty cell, with start pulsed in the done cycle
        run_cell(0, 200, 1'b0, 4);
        check_eq("t2_no_valid", any_valid, 0);
        check_eq("t2_done_lat", done_cyc - start_cyc, 4);
        check_eq("t2_busy_at_done", busy_at_done, 1);
        check_eq("t2_busy_after_done", busy_after_done, 0);
        check_eq("t2_cell_count", cell_count, 0);

        // random backpressure
        run_cell(8, 300, 1'b1, -1);
        check_eq("t3_fifo_max_le4", max_occ <= FIFO_DEPTH, 1);
        check_eq("t3_cell_count", cell_count, 8);

        // count beyond memory depth is clamped
        run_cell(255, 400, 1'b0, -1);
        check_eq("t4_cell_count", cell_count, 219);
        check_eq("t4_next_id", exp_id, 220);

        // start while streaming is ignored
        run_cell(6, 500, 1'b1, 10);
        check_eq("t5_cell_count", cell_count, 6);

        // reset mid-stream, then clean restart
        arm(10, 600);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (words < 2 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("t6_reached_word3", words >= 2, 1);
        check_eq("t6_word3_valid", pos_valid, 1);
        rst_n = 1'b0;
        mon_en = 1'b0;
        #2;
        check_eq("t6_rst_valid", pos_valid, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_done", done, 0);
        check_eq("t6_rst_count", cell_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_cell(10, 700, 1'b0, -1);
        check_eq("t6_restart_lat", first_valid - start_cyc, 7);
        check_eq("t6_cell_count", cell_count, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
